// File: rtl/ibex_prefetch_buffer_mo.sv
// ibex_prefetch_buffer_mo: multi-outstanding instruction prefetcher with an in-order response FIFO,
// branch squashing of in-flight responses and fetch stall after a bus error.
module ibex_prefetch_buffer_mo #(
    parameter int NUM_OUTSTANDING = 2,
    parameter int FIFO_DEPTH      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_rvalid_i,
    input  logic        instr_err_i,
    output logic        busy_o
);
    localparam int OW = $clog2(NUM_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [OW-1:0] MAX_OUT = OW'(NUM_OUTSTANDING);
    localparam logic [CW:0]   DEPTH   = (CW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        err;
    } entry_t;

    logic [OW-1:0] outstanding_q, outstanding_d, discard_q, discard_d, live;
    logic [CW-1:0] cnt_q, cnt_d, wr_idx;
    logic [CW:0]   credit;
    logic          err_stall_q, err_stall_d;
    logic [31:0]   fetch_addr_q, fetch_addr_d, rsp_addr_q, rsp_addr_d;
    entry_t        fifo_q [FIFO_DEPTH];
    entry_t        fifo_d [FIFO_DEPTH];
    logic          grant, push, pop;
    logic          unused_addr0;

    assign unused_addr0 = addr_i[0];
    assign live         = outstanding_q - discard_q;
    // Credit counts buffered plus live in-flight words, so every accepted response has a slot.
    assign credit       = {1'b0, cnt_q} + (CW+1)'(live);
    assign instr_req_o  = req_i & (~err_stall_q | branch_i) & (outstanding_q < MAX_OUT) &
                          (branch_i | (credit < DEPTH));
    assign instr_addr_o = branch_i ? {addr_i[31:2], 2'b00} : fetch_addr_q;
    assign grant        = instr_req_o & instr_gnt_i;
    assign push         = instr_rvalid_i & (discard_q == '0) & ~branch_i;
    assign valid_o      = (cnt_q != '0) & ~branch_i;
    assign pop          = valid_o & ready_i;
    assign wr_idx       = cnt_q - CW'(pop);
    assign rdata_o      = fifo_q[0].rdata;
    assign addr_o       = fifo_q[0].addr;
    assign err_o        = fifo_q[0].err;
    assign busy_o       = (outstanding_q != '0) | instr_req_o;

    always_comb begin
        outstanding_d = outstanding_q + OW'(grant) - OW'(instr_rvalid_i);
        discard_d     = branch_i ? outstanding_q - OW'(instr_rvalid_i)
                                 : discard_q - OW'(instr_rvalid_i & (discard_q != '0));
        fetch_addr_d  = grant ? instr_addr_o + 32'd4 : branch_i ? instr_addr_o : fetch_addr_q;
        rsp_addr_d    = branch_i ? {addr_i[31:1], 1'b0}
                      : push ? {rsp_addr_q[31:2], 2'b00} + 32'd4 : rsp_addr_q;
        err_stall_d   = ~branch_i & (err_stall_q | (push & instr_err_i));
        cnt_d         = branch_i ? '0 : cnt_q + CW'(push) - CW'(pop);
        for (int i = 0; i < FIFO_DEPTH - 1; i++) fifo_d[i] = pop ? fifo_q[i+1] : fifo_q[i];
        fifo_d[FIFO_DEPTH-1] = fifo_q[FIFO_DEPTH-1];
        for (int i = 0; i < FIFO_DEPTH; i++)
            if (push && wr_idx == CW'(i)) fifo_d[i] = {instr_rdata_i, rsp_addr_q, instr_err_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
            discard_q     <= '0;
            err_stall_q   <= 1'b0;
            fetch_addr_q  <= '0;
            rsp_addr_q    <= '0;
            cnt_q         <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            err_stall_q   <= err_stall_d;
            fetch_addr_q  <= fetch_addr_d;
            rsp_addr_q    <= rsp_addr_d;
            cnt_q         <= cnt_d;
            fifo_q        <= fifo_d;
        end
    end
endmodule

// File: tb/tb_ibex_prefetch_buffer_mo.sv
// tb_ibex_prefetch_buffer_mo: directed scenarios against a one-cycle-latency in-order bus model.
module tb_ibex_prefetch_buffer_mo;
    logic        clk = 1'b0;
    logic        rst_n, req_i, branch_i, ready_i, valid_o, err_o;
    logic [31:0] addr_i, rdata_o, addr_o, instr_addr_o, instr_rdata_i;
    logic        instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i, busy_o;
    bit          rsp_en;
    logic [31:0] err_addr;
    logic [31:0] pend[$];
    int          checks = 0, passed = 0;

    ibex_prefetch_buffer_mo dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
        .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o), .err_o(err_o),
        .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
        .instr_rdata_i(instr_rdata_i), .instr_rvalid_i(instr_rvalid_i), .instr_err_i(instr_err_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hDEAD0000;
    endfunction

    // Called a little after a negedge: records this cycle's handshakes, then moves to the next negedge.
    task automatic tick();
        if (instr_rvalid_i) void'(pend.pop_front());
        if (instr_req_o && instr_gnt_i) pend.push_back(instr_addr_o);
        @(negedge clk);
        instr_rvalid_i = rsp_en && pend.size() != 0;
        instr_rdata_i  = instr_rvalid_i ? dat(pend[0]) : 32'h0;
        instr_err_i    = instr_rvalid_i && pend[0] == err_addr;
    endtask

    task automatic drain();
        req_i = 0; branch_i = 0; ready_i = 1; instr_gnt_i = 1; rsp_en = 1;
        repeat (8) begin #1; tick(); end
        #1;
        checks++; if (valid_o !== 1'b0) $display("FAIL drain_valid got %b exp 0", valid_o); else passed++;
        checks++; if (busy_o !== 1'b0) $display("FAIL drain_busy got %b exp 0", busy_o); else passed++;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 0; req_i = 0; branch_i = 0; addr_i = 0; ready_i = 0; instr_gnt_i = 0;
        instr_rvalid_i = 0; instr_rdata_i = 0; instr_err_i = 0; rsp_en = 0; err_addr = 32'h1;
        @(negedge clk); #1;
        checks++; if (valid_o !== 1'b0) $display("FAIL rst_valid got %b exp 0", valid_o); else passed++;
        checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy_o); else passed++;
        checks++; if (instr_req_o !== 1'b0) $display("FAIL rst_req got %b exp 0", instr_req_o); else passed++;
        rst_n = 1;
        tick(); #1;
        checks++; if (instr_req_o !== 1'b0) $display("FAIL idle_req got %b exp 0", instr_req_o); else passed++;
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] e;
        req_i = 1; ready_i = 1; instr_gnt_i = 1; rsp_en = 1;
        for (int k = 0; k < 8; k++) begin
            branch_i = (k == 0); addr_i = 32'h100;
            #1;
            e = 32'h100 + 4 * k;
            checks++; if (instr_req_o !== 1'b1) $display("FAIL stream_req k=%0d got %b exp 1", k, instr_req_o); else passed++;
            checks++; if (instr_addr_o !== e) $display("FAIL stream_baddr k=%0d got %h exp %h", k, instr_addr_o, e); else passed++;
            checks++; if (pend.size() > 2) $display("FAIL stream_outstanding k=%0d got %0d exp <=2", k, pend.size()); else passed++;
            if (k >= 2) begin
                e = 32'h100 + 4 * (k - 2);
                checks++; if (valid_o !== 1'b1) $display("FAIL stream_valid k=%0d got %b exp 1", k, valid_o); else passed++;
                checks++; if (addr_o !== e) $display("FAIL stream_addr k=%0d got %h exp %h", k, addr_o, e); else passed++;
                checks++; if (rdata_o !== dat(e)) $display("FAIL stream_rdata k=%0d got %h exp %h", k, rdata_o, dat(e)); else passed++;
            end
            tick();
        end
        drain();
    endtask

    task automatic test_backpressure();
        int g;
        logic [31:0] ga;
        req_i = 1; ready_i = 0; instr_gnt_i = 1; rsp_en = 1; g = 0; ga = 0;
        for (int k = 0; k < 10; k++) begin
            branch_i = (k == 0); addr_i = 32'h600;
            #1;
            if (instr_req_o && instr_gnt_i) g++;
            tick();
        end
        branch_i = 0; #1;
        checks++; if (g !== 3) $display("FAIL bp_grants got %0d exp 3", g); else passed++;
        checks++; if (instr_req_o !== 1'b0) $display("FAIL bp_req got %b exp 0", instr_req_o); else passed++;
        checks++; if (valid_o !== 1'b1) $display("FAIL bp_valid got %b exp 1", valid_o); else passed++;
        checks++; if (addr_o !== 32'h600) $display("FAIL bp_hold_addr got %h exp 00000600", addr_o); else passed++;
        checks++; if (rdata_o !== dat(32'h600)) $display("FAIL bp_hold_rdata got %h exp %h", rdata_o, dat(32'h600)); else passed++;
        ready_i = 1;
        tick();
        ready_i = 0; g = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (instr_req_o && instr_gnt_i) begin g++; ga = instr_addr_o; end
            tick();
        end
        #1;
        checks++; if (g !== 1) $display("FAIL bp_refill_grants got %0d exp 1", g); else passed++;
        checks++; if (ga !== 32'h60C) $display("FAIL bp_refill_addr got %h exp 0000060c", ga); else passed++;
        checks++; if (addr_o !== 32'h604) $display("FAIL bp_head_after_pop got %h exp 00000604", addr_o); else passed++;
        drain();
    endtask

    task automatic test_discard();
        req_i = 1; ready_i = 1; instr_gnt_i = 1; rsp_en = 0;
        branch_i = 1; addr_i = 32'h700; #1; tick();
        branch_i = 0; #1; tick();
        branch_i = 1; addr_i = 32'h200; rsp_en = 1; #1;
        checks++; if (instr_req_o !== 1'b0) $display("FAIL disc_full_req got %b exp 0", instr_req_o); else passed++;
        tick();
        branch_i = 0;
        for (int k = 1; k < 6; k++) begin
            #1;
            checks++; if (valid_o !== (k >= 4)) $display("FAIL disc_valid k=%0d got %b exp %b", k, valid_o, k >= 4); else passed++;
            if (k == 2) begin
                checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h200)
                    $display("FAIL disc_refetch got req=%b addr=%h exp req=1 addr=00000200", instr_req_o, instr_addr_o); else passed++;
            end
            if (k == 4) begin
                checks++; if (addr_o !== 32'h200) $display("FAIL disc_first got %h exp 00000200", addr_o); else passed++;
            end
            if (k == 5) begin
                checks++; if (addr_o !== 32'h204) $display("FAIL disc_second got %h exp 00000204", addr_o); else passed++;
            end
            tick();
        end
        drain();
    endtask

    task automatic test_compressed();
        req_i = 1; ready_i = 1; instr_gnt_i = 1; rsp_en = 1;
        for (int k = 0; k < 4; k++) begin
            branch_i = (k == 0); addr_i = 32'h302;
            #1;
            if (k == 0) begin
                checks++; if (instr_addr_o !== 32'h300) $display("FAIL cmp_baddr got %h exp 00000300", instr_addr_o); else passed++;
            end
            if (k == 1) begin
                checks++; if (instr_addr_o !== 32'h304) $display("FAIL cmp_baddr2 got %h exp 00000304", instr_addr_o); else passed++;
            end
            if (k == 2) begin
                checks++; if (valid_o !== 1'b1 || addr_o !== 32'h302)
                    $display("FAIL cmp_first got v=%b addr=%h exp v=1 addr=00000302", valid_o, addr_o); else passed++;
            end
            if (k == 3) begin
                checks++; if (addr_o !== 32'h304) $display("FAIL cmp_second got %h exp 00000304", addr_o); else passed++;
            end
            tick();
        end
        drain();
    endtask

    task automatic test_error();
        err_addr = 32'h104; req_i = 1; ready_i = 1; instr_gnt_i = 1; rsp_en = 1;
        for (int k = 0; k < 4; k++) begin
            branch_i = (k == 0); addr_i = 32'h100;
            #1;
            if (k == 2) begin
                checks++; if (err_o !== 1'b0) $display("FAIL err_clean got %b exp 0", err_o); else passed++;
            end
            if (k == 3) begin
                checks++; if (valid_o !== 1'b1 || addr_o !== 32'h104 || err_o !== 1'b1)
                    $display("FAIL err_entry got v=%b addr=%h err=%b exp v=1 addr=00000104 err=1", valid_o, addr_o, err_o); else passed++;
                checks++; if (instr_req_o !== 1'b0) $display("FAIL err_stall_req got %b exp 0", instr_req_o); else passed++;
            end
            tick();
        end
        branch_i = 0;
        repeat (4) begin #1; tick(); end
        #1;
        checks++; if (instr_req_o !== 1'b0) $display("FAIL err_still_stalled got %b exp 0", instr_req_o); else passed++;
        branch_i = 1; addr_i = 32'h400; #1;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h400)
            $display("FAIL err_resume got req=%b addr=%h exp req=1 addr=00000400", instr_req_o, instr_addr_o); else passed++;
        tick();
        branch_i = 0; #1;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h404)
            $display("FAIL err_resume2 got req=%b addr=%h exp req=1 addr=00000404", instr_req_o, instr_addr_o); else passed++;
        tick(); #1;
        checks++; if (valid_o !== 1'b1 || addr_o !== 32'h400 || err_o !== 1'b0)
            $display("FAIL err_after got v=%b addr=%h err=%b exp v=1 addr=00000400 err=0", valid_o, addr_o, err_o); else passed++;
        tick();
        err_addr = 32'h1;
        drain();
    endtask

    task automatic test_wait_grant();
        logic [31:0] e;
        req_i = 1; ready_i = 1; instr_gnt_i = 1; rsp_en = 1;
        branch_i = 1; addr_i = 32'h100; #1; tick();
        branch_i = 0; #1; tick();
        instr_gnt_i = 0;
        for (int w = 0; w < 4; w++) begin
            branch_i = (w == 2); addr_i = 32'h500;
            #1;
            e = (w >= 2) ? 32'h500 : 32'h108;
            checks++; if (instr_req_o !== 1'b1) $display("FAIL wg_req w=%0d got %b exp 1", w, instr_req_o); else passed++;
            checks++; if (instr_addr_o !== e) $display("FAIL wg_addr w=%0d got %h exp %h", w, instr_addr_o, e); else passed++;
            tick();
        end
        branch_i = 0; instr_gnt_i = 1; #1;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h500)
            $display("FAIL wg_grant got req=%b addr=%h exp req=1 addr=00000500", instr_req_o, instr_addr_o); else passed++;
        tick();
        #1; tick(); #1;
        checks++; if (valid_o !== 1'b1 || addr_o !== 32'h500)
            $display("FAIL wg_data got v=%b addr=%h exp v=1 addr=00000500", valid_o, addr_o); else passed++;
        tick();
        drain();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_discard();
        test_compressed();
        test_error();
        test_wait_grant();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
